drap_dmemory_subword: RTL and testbench

DRAP_DMEMORY_SUBWORD -- requirements
Module: drap_dmemory_subword

---
 rtl/drap_dmem_pkg.sv | 27 ++
 rtl/drap_dmem_array.sv | 31 +++
 rtl/drap_dmemory_subword.sv | 164 ++++++++++++++++
 tb/tb_drap_dmemory_subword.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drap_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drap_dmem_pkg
//  Brief    : Shared encodings for the sub-word data memory.
//  Revision : 1.0
// ============================================================================
package drap_dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Reserved size is treated as a rejected access alongside misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/drap_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : drap_dmem_array
//  Brief    : 32-bit synchronous RAM, byte-write enables, registered read.
//  Revision : 1.0
// ============================================================================
module drap_dmem_array #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/drap_dmemory_subword.sv
`default_nettype none
// ============================================================================
//  Module   : drap_dmemory_subword
//  Brief    : Wait-stated data memory with big-endian byte/half/word access.
//  Revision : 1.0
// ============================================================================
module drap_dmemory_subword
  import drap_dmem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata
);

  localparam logic [3:0] C_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [1:0] C_FIRST = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err_pend;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic [31:0] w_arr_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_off = r_addr[1:0];

  // Store steering: replicate the datum across lanes and let byte enables pick.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = 32'h0;
    case (r_size)
      SZ_BYTE: begin
        w_be    = 4'b1000 >> w_off;
        w_wlane = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h0;
    case (w_off)
      2'd0:    w_byte = w_arr_rdata[31:24];
      2'd1:    w_byte = w_arr_rdata[23:16];
      2'd2:    w_byte = w_arr_rdata[15:8];
      default: w_byte = w_arr_rdata[7:0];
    endcase
  end

  assign w_half = w_off[1] ? w_arr_rdata[15:0] : w_arr_rdata[31:16];

  always_comb begin
    w_load = w_arr_rdata;
    case (r_size)
      SZ_BYTE: w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = w_arr_rdata;
    endcase
  end

  drap_dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_be    ((r_state == ST_ACCESS && r_we) ? w_be : 4'b0000),
    .i_wdata (w_wlane),
    .i_re    (r_state == ST_ACCESS && !r_we),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_err_pend <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_uns   <= uns;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (misaligned(size, addr[1:0])) begin
              r_err_pend <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_err_pend <= 1'b0;
              r_cnt      <= C_WAIT;
              r_state    <= C_FIRST;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACCESS: r_state <= ST_RESP;
        default: begin
          // Array read data is valid here, one edge after ACCESS issued it.
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_err   <= r_err_pend;
          if (!r_err_pend && !r_we) r_rdata <= w_load;
        end
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_drap_dmemory_subword.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drap_dmemory_subword
//  Brief    : Self-checking bench with a word-array model of the memory.
//  Revision : 1.0
// ============================================================================
module tb_drap_dmemory_subword;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        req3 = 1'b0, we3 = 1'b0, uns3 = 1'b0;
  logic [1:0]  size3 = 2'b10;
  logic [8:0]  addr3 = '0;
  logic [31:0] wdata3 = '0;
  logic        ready3, done3, err3;
  logic [31:0] rdata3;

  int tests = 0;
  int fails = 0;
  int e = 0;

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  drap_dmemory_subword #(.ADDR_W(7), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata));

  drap_dmemory_subword #(.ADDR_W(7), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .size(size3), .uns(uns3),
    .addr(addr3), .wdata(wdata3), .ready(ready3), .done(done3), .err(err3), .rdata(rdata3));

  // Model state: memory words plus the one request in flight.
  logic [31:0] mm [128];
  bit          p_valid = 1'b0;
  int          p_acc, p_done;
  bit          p_we, p_uns, p_err;
  logic [1:0]  p_size;
  logic [8:0]  p_addr;
  logic [31:0] p_wdata;
  logic [31:0] m_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bad(input logic [1:0] sz, input int off);
    return (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] sz, input bit u, input int off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (3 - off))) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] st(input logic [31:0] w, input logic [1:0] sz, input int off, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * (3 - off); mask = 32'hFF << sh;
      return (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = (off >= 2) ? 0 : 16; mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    bit xd, xe, xr;
    if (rst_n) begin
      xd = 1'b0; xe = 1'b0;
      if (p_valid && e == p_done) begin
        xd = 1'b1; xe = p_err;
        if (!p_err) begin
          if (p_we) mm[p_addr[8:2]] = st(mm[p_addr[8:2]], p_size, int'(p_addr[1:0]), p_wdata);
          else      m_rdata = ld(mm[p_addr[8:2]], p_size, p_uns, int'(p_addr[1:0]));
        end
        p_valid = 1'b0;
      end
      xr = !(p_valid && e >= p_acc && e < p_done);
      check("ready", {31'b0, ready}, {31'b0, xr});
      check("done",  {31'b0, done},  {31'b0, xd});
      check("err",   {31'b0, err},   {31'b0, xe});
      check("rdata", rdata, m_rdata);
    end
  end

  task automatic issue(input bit we_i, input logic [1:0] sz_i, input bit u_i,
                       input logic [8:0] a_i, input logic [31:0] d_i,
                       output int lat_o, output logic err_o);
    int guard = 0;
    int acc;
    @(negedge clk); #1;
    while (p_valid && guard < 50) begin @(negedge clk); #1; guard++; end
    req = 1'b1; we = we_i; size = sz_i; uns = u_i; addr = a_i; wdata = d_i;
    @(posedge clk); #1;
    acc = e;
    p_we = we_i; p_size = sz_i; p_uns = u_i; p_addr = a_i; p_wdata = d_i;
    p_err = bad(sz_i, int'(a_i[1:0]));
    p_acc = acc;
    p_done = acc + (p_err ? 1 : W + 2);
    p_valid = 1'b1;
    req = 1'b0;
    lat_o = -1; err_o = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) begin lat_o = e - acc; err_o = err; break; end
    end
    if (lat_o < 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got none expected done within 40 cycles");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_valid = 1'b0;
    m_rdata = 32'h0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_err",   {31'b0, err},   32'd0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    logic er;
    int cnt, first;

    #12;
    do_reset();

    // Word store/load round trip and latency
    issue(1, 2'd2, 0, 9'h000, 32'h55555555, lat, er);
    check("st_w_lat", lat, W + 2);
    issue(0, 2'd2, 0, 9'h000, 32'h0, lat, er);
    check("ld_w_lat", lat, W + 2);
    check("ld_w_err", {31'b0, er}, 32'd0);
    check("ld_w_0", rdata, 32'h55555555);

    // Byte lanes within word 1
    issue(1, 2'd2, 0, 9'h004, 32'hAAAAAAAA, lat, er);
    issue(1, 2'd0, 0, 9'h006, 32'h00000080, lat, er);
    issue(0, 2'd0, 0, 9'h006, 32'h0, lat, er);
    check("ld_b_s", rdata, 32'hFFFFFF80);
    issue(0, 2'd0, 1, 9'h006, 32'h0, lat, er);
    check("ld_b_u", rdata, 32'h00000080);
    issue(0, 2'd2, 0, 9'h004, 32'h0, lat, er);
    check("ld_w_4", rdata, 32'hAAAA80AA);
    issue(0, 2'd0, 0, 9'h004, 32'h0, lat, er);
    check("ld_b_off0", rdata, 32'hFFFFFFAA);

    // Halves at the last word
    issue(1, 2'd2, 0, 9'h1FC, 32'hCAFEF00D, lat, er);
    issue(1, 2'd1, 0, 9'h1FE, 32'h00001234, lat, er);
    issue(0, 2'd1, 0, 9'h1FE, 32'h0, lat, er);
    check("ld_h_lo", rdata, 32'h00001234);
    issue(0, 2'd2, 0, 9'h1FC, 32'h0, lat, er);
    check("ld_w_127", rdata, 32'hCAFE1234);
    issue(0, 2'd1, 0, 9'h1FC, 32'h0, lat, er);
    check("ld_h_hi_s", rdata, 32'hFFFFCAFE);

    // Rejected accesses
    issue(0, 2'd2, 0, 9'h002, 32'h0, lat, er);
    check("mis_w_lat", lat, 1);
    check("mis_w_err", {31'b0, er}, 32'd1);
    check("mis_w_rdata", rdata, 32'hFFFFCAFE);
    issue(1, 2'd3, 0, 9'h000, 32'hDEADDEAD, lat, er);
    check("rsv_lat", lat, 1);
    check("rsv_err", {31'b0, er}, 32'd1);
    issue(1, 2'd1, 0, 9'h005, 32'h0000BEEF, lat, er);
    check("mis_h_err", {31'b0, er}, 32'd1);
    issue(0, 2'd2, 0, 9'h000, 32'h0, lat, er);
    check("unchanged_0", rdata, 32'h55555555);
    issue(0, 2'd2, 0, 9'h004, 32'h0, lat, er);
    check("unchanged_4", rdata, 32'hAAAA80AA);

    // Reset during WAIT aborts the store
    issue(1, 2'd2, 0, 9'h008, 32'h11111111, lat, er);
    @(negedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 9'h008; wdata = 32'h22222222;
    @(posedge clk); #1;
    req = 1'b0;
    check("in_wait_ready", {31'b0, ready}, 32'd0);
    do_reset();
    issue(0, 2'd2, 0, 9'h008, 32'h0, lat, er);
    check("abort_kept", rdata, 32'h11111111);

    // Held request on the 3-wait-state instance
    @(negedge clk); #1;
    req3 = 1'b1; we3 = 1'b1; size3 = 2'd2; addr3 = 9'h010; wdata3 = 32'hDEADBEEF;
    cnt = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("w3_busy", {31'b0, ready3}, 32'd0);
      if (i == 2) req3 = 1'b0;
      if (done3) begin cnt++; if (first < 0) first = i; end
    end
    check("w3_pulses", cnt, 1);
    check("w3_lat", first, 5);
    @(negedge clk); #1;
    req3 = 1'b1; we3 = 1'b0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin req3 = 1'b0; check("w3_acc2", {31'b0, ready3}, 32'd0); end
      if (done3 && first < 0) first = i;
    end
    check("w3_ld_lat", first, 5);
    check("w3_ld", rdata3, 32'hDEADBEEF);
    check("w3_ld_err", {31'b0, err3}, 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
